// File: rtl/addsub_seq.sv
// addsub_seq: multi-word adder/subtractor built around one WIDTH-bit slice.
// An N-bit operation (N = WIDTH*WORDS) takes one slice per clock, LSB slice
// first, with the slice carry/borrow held in a flop between cycles.
// Results (y, c_out, z_out) change only when the final slice completes.

module addsub_seq #(
   parameter int WIDTH = 8,
   parameter int WORDS = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     op,
   input  logic                     use_c,
   input  logic                     c_in,
   input  logic [WIDTH*WORDS-1:0]   a,
   input  logic [WIDTH*WORDS-1:0]   b,
   output logic                     busy,
   output logic                     done,
   output logic [WIDTH*WORDS-1:0]   y,
   output logic                     c_out,
   output logic                     z_out
);

   localparam int N     = WIDTH * WORDS;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // One slice of the datapath: returns {carry_or_borrow, sum_or_difference}.
   // Subtraction is done at WIDTH+1 bits so the top bit of the difference is
   // exactly the borrow (a_i < b_i + cin).
   function automatic logic [WIDTH:0] slice_addsub(
      input logic [WIDTH-1:0] x,
      input logic [WIDTH-1:0] w,
      input logic             sub,
      input logic             cin
   );
      logic [WIDTH:0] xe;
      logic [WIDTH:0] we;
      logic [WIDTH:0] ce;
      logic [WIDTH:0] r;
      xe = {1'b0, x};
      we = {1'b0, w};
      ce = {{WIDTH{1'b0}}, cin};
      if (sub) begin
         r = xe - we - ce;
      end else begin
         r = xe + we + ce;
      end
      return r;
   endfunction

   // All-zero detect for the completed result word.
   function automatic logic is_zero(input logic [N-1:0] v);
      return (v == {N{1'b0}});
   endfunction

   // Registered state
   state_t           state_q, state_d;
   logic [N-1:0]     a_q, a_d;
   logic [N-1:0]     b_q, b_d;
   logic             op_q, op_d;
   logic             carry_q, carry_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [N-1:0]     acc_q, acc_d;
   logic [N-1:0]     y_q, y_d;
   logic             c_out_q, c_out_d;
   logic             z_out_q, z_out_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // Slice datapath signals
   logic [WIDTH-1:0] a_slice_s;
   logic [WIDTH-1:0] b_slice_s;
   logic [WIDTH:0]   slice_res_s;
   logic [WIDTH-1:0] slice_sum_s;
   logic             slice_cout_s;

   // Select the operand slice addressed by the slice index and run it through
   // the single shared add/sub slice.
   always_comb begin
      a_slice_s    = a_q[idx_q*WIDTH +: WIDTH];
      b_slice_s    = b_q[idx_q*WIDTH +: WIDTH];
      slice_res_s  = slice_addsub(a_slice_s, b_slice_s, op_q, carry_q);
      slice_sum_s  = slice_res_s[WIDTH-1:0];
      slice_cout_s = slice_res_s[WIDTH];
   end

   // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      y_d     = y_q;
      c_out_d = c_out_q;
      z_out_d = z_out_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            // start beats abort whenever the block is not busy
            if (start) begin
               state_d = ST_RUN;
               a_d     = a;
               b_d     = b;
               op_d    = op;
               carry_d = use_c & c_in;
               idx_d   = IDX_ZERO;
               acc_d   = {N{1'b0}};
               busy_d  = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_RUN: begin
            // abort wins even on the final slice: nothing is committed
            if (abort) begin
               state_d = ST_IDLE;
               idx_d   = IDX_ZERO;
            end else begin
               acc_d[idx_q*WIDTH +: WIDTH] = slice_sum_s;
               carry_d = slice_cout_s;
               if (idx_q == LAST_IDX) begin
                  state_d = ST_DONE;
                  idx_d   = IDX_ZERO;
                  y_d     = acc_d;
                  c_out_d = slice_cout_s;
                  z_out_d = is_zero(acc_d);
                  done_d  = 1'b1;
               end else begin
                  idx_d  = idx_q + IDX_ONE;
                  busy_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            idx_d   = IDX_ZERO;
         end
      endcase
   end

   // State, working and output registers; reset clears everything at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= {N{1'b0}};
         b_q     <= {N{1'b0}};
         op_q    <= 1'b0;
         carry_q <= 1'b0;
         idx_q   <= IDX_ZERO;
         acc_q   <= {N{1'b0}};
         y_q     <= {N{1'b0}};
         c_out_q <= 1'b0;
         z_out_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         y_q     <= y_d;
         c_out_q <= c_out_d;
         z_out_q <= z_out_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign y     = y_q;
   assign c_out = c_out_q;
   assign z_out = z_out_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Testbench for addsub_seq: directed vectors with hand-computed results.
// Stimulus pushes expected results into a scoreboard queue; a monitor pops
// and compares whenever done is high.

module tb_addsub_seq;

   localparam int WIDTH = 8;
   localparam int WORDS = 4;
   localparam int N     = WIDTH * WORDS;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic         op    = 1'b0;
   logic         use_c = 1'b0;
   logic         c_in  = 1'b0;
   logic [N-1:0] a     = 32'h0;
   logic [N-1:0] b     = 32'h0;
   logic         busy;
   logic         done;
   logic [N-1:0] y;
   logic         c_out;
   logic         z_out;

   // single-slice instance for the WORDS=1 corner
   logic         s1_start = 1'b0;
   logic         s1_abort = 1'b0;
   logic         s1_op    = 1'b0;
   logic         s1_use_c = 1'b0;
   logic         s1_c_in  = 1'b0;
   logic [7:0]   s1_a     = 8'h0;
   logic [7:0]   s1_b     = 8'h0;
   logic         s1_busy;
   logic         s1_done;
   logic [7:0]   s1_y;
   logic         s1_c_out;
   logic         s1_z_out;

   typedef struct packed {
      logic [N-1:0] y;
      logic         c;
      logic         z;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_vec    = 0;
   int   n_bad    = 0;
   int   edge_cnt = 0;

   addsub_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .op(op),
      .use_c(use_c), .c_in(c_in), .a(a), .b(b), .busy(busy), .done(done),
      .y(y), .c_out(c_out), .z_out(z_out)
   );

   addsub_seq #(.WIDTH(8), .WORDS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(s1_start), .abort(s1_abort), .op(s1_op),
      .use_c(s1_use_c), .c_in(s1_c_in), .a(s1_a), .b(s1_b), .busy(s1_busy),
      .done(s1_done), .y(s1_y), .c_out(s1_c_out), .z_out(s1_z_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic push_exp(input logic [N-1:0] ey, input logic ec, input logic ez);
      exp_t t;
      t.y = ey;
      t.c = ec;
      t.z = ez;
      sb_q.push_back(t);
   endtask

   // monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb_q.size() == 0) begin
            check("unexpected_done", done, 1'b0);
         end else begin
            mon_e = sb_q.pop_front();
            check("result", {y, c_out, z_out}, {mon_e.y, mon_e.c, mon_e.z});
         end
      end
   end

   // wait (bounded) for done; returns edge count at observation and busy cycles
   task automatic wait_done(output int at_edge, output int busy_cycles);
      int w;
      w = 0;
      busy_cycles = 0;
      while (!done && w < 20) begin
         if (busy) busy_cycles++;
         @(negedge clk);
         w++;
      end
      check("done_seen", done, 1'b1);
      at_edge = edge_cnt;
   endtask

   // one full operation from IDLE with timing checks; operands are scrambled
   // after the sampling edge to show they were latched
   task automatic run_op(input logic o, input logic uc, input logic ci,
                         input logic [N-1:0] av, input logic [N-1:0] bv,
                         input logic ab,
                         input logic [N-1:0] ey, input logic ec, input logic ez);
      int k;
      int de;
      int bc;
      @(negedge clk);
      op = o; use_c = uc; c_in = ci; a = av; b = bv; abort = ab; start = 1'b1;
      push_exp(ey, ec, ez);
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      k = edge_cnt;
      a = ~av; b = ~bv; op = ~o; c_in = ~ci;
      wait_done(de, bc);
      check("latency_edges", de - k + 1, WORDS + 1);
      check("busy_cycles", bc, WORDS);
      check("busy_at_done", busy, 1'b0);
      @(negedge clk);
      check("done_one_cycle", done, 1'b0);
   endtask

   initial begin
      int d1;
      int d2;
      int bc;

      // reset state, checked before any clock edge
      #1 rst_n = 1'b0;
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_y", y, 32'h0);
      check("rst_cz", {c_out, z_out}, 2'b00);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // directed vectors: op, use_c, c_in, a, b, abort, y, c_out, z_out
      run_op(1'b0, 1'b0, 1'b0, 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0);
      run_op(1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b1);
      run_op(1'b1, 1'b0, 1'b0, 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
      run_op(1'b1, 1'b1, 1'b1, 32'h00000010, 32'h0000000F, 1'b0, 32'h00000000, 1'b0, 1'b1);
      run_op(1'b1, 1'b0, 1'b1, 32'h00000010, 32'h0000000F, 1'b0, 32'h00000001, 1'b0, 1'b0);
      run_op(1'b0, 1'b1, 1'b1, 32'h12345678, 32'h11111111, 1'b0, 32'h2345678A, 1'b0, 1'b0);
      run_op(1'b1, 1'b0, 1'b0, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0);
      run_op(1'b0, 1'b0, 1'b1, 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0);
      run_op(1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b0, 32'h00000000, 1'b1, 1'b1);
      // start together with abort while idle: start wins
      run_op(1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 32'h00000000, 1'b0, 1'b1);

      // start pulsed mid-RUN with different operands is ignored
      @(negedge clk);
      op = 1'b0; use_c = 1'b0; a = 32'h00000005; b = 32'h00000003; start = 1'b1;
      push_exp(32'h00000008, 1'b0, 1'b0);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; op = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(d1, bc);
      repeat (8) @(negedge clk);
      check("idle_after_ignored_start", busy, 1'b0);

      // start held through DONE: back-to-back with no idle cycle
      @(negedge clk);
      op = 1'b0; use_c = 1'b0; a = 32'h000000FF; b = 32'h00000001; start = 1'b1;
      push_exp(32'h00000100, 1'b0, 1'b0);
      @(negedge clk);
      op = 1'b1; a = 32'h00000100; b = 32'h00000001;
      push_exp(32'h000000FF, 1'b0, 1'b0);
      wait_done(d1, bc);
      @(negedge clk);
      check("b2b_no_idle", busy, 1'b1);
      start = 1'b0;
      wait_done(d2, bc);
      check("b2b_done_spacing", d2 - d1, WORDS + 1);

      // abort sampled at the 2nd RUN edge
      repeat (2) @(negedge clk);
      op = 1'b0; a = 32'h00000001; b = 32'h00000001; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", busy, 1'b0);
      check("abort_y_kept", {y, c_out, z_out}, {32'h000000FF, 1'b0, 1'b0});
      repeat (8) @(negedge clk);

      // abort sampled on the same edge as the last slice
      op = 1'b0; a = 32'h00000000; b = 32'h00000000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (WORDS - 1) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_last_done", done, 1'b0);
      check("abort_last_y_kept", {y, c_out, z_out}, {32'h000000FF, 1'b0, 1'b0});
      repeat (8) @(negedge clk);

      // WORDS=1 instance: done one edge after RUN entry
      s1_op = 1'b0; s1_a = 8'hF0; s1_b = 8'h20; s1_start = 1'b1;
      @(negedge clk);
      s1_start = 1'b0;
      check("w1_busy", {s1_busy, s1_done}, 2'b10);
      @(negedge clk);
      check("w1_result", {s1_done, s1_y, s1_c_out, s1_z_out}, {1'b1, 8'h10, 1'b1, 1'b0});

      // reset mid-RUN: outputs clear immediately, no done after release
      @(negedge clk);
      op = 1'b0; a = 32'h00000001; b = 32'h00000002; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrun_rst_outputs", {busy, done, y, c_out, z_out}, 36'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check("post_rst_idle", busy, 1'b0);

      // operation after reset still works
      run_op(1'b0, 1'b0, 1'b0, 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0);

      repeat (2) @(negedge clk);
      check("scoreboard_drained", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   // global time bound so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/addsub_seq.md
ADDSUB_SEQ -- requirements
Module: addsub_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8: slice width of the shared adder/subtractor, in bits.
REQ-002 SHALL have parameter WORDS, default 4: number of slices per operand. Full operand width N = WIDTH*WORDS.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  request a new operation; sampled only when busy=0.
REQ-006 abort  in  1  cancel an operation in progress.
REQ-007 op  in  1  operation select: 0 add, 1 subtract.
REQ-008 use_c  in  1  1: c_in feeds slice 0; 0: slice 0 carry/borrow-in forced to 0.
REQ-009 c_in  in  1  external carry/borrow-in.
REQ-010 a, b  in  N  operands.
REQ-011 busy  out  1  operation in progress.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 y  out  N  result of the last completed operation.
REQ-014 c_out  out  1  final carry (add) or borrow (sub) of the last completed operation.
REQ-015 z_out  out  1  1 when y of the last completed operation is all zeros.

Function
REQ-016 SHALL implement states IDLE, RUN and DONE, and SHALL contain exactly one WIDTH-bit add/sub slice, reused once per cycle.
REQ-017 IDLE/DONE + start=1 at edge k: SHALL latch a, b, op and the initial carry (use_c ? c_in : 0), clear the slice index, and enter RUN; busy=1 from edge k.
REQ-018 RUN: at each edge k+1..k+WORDS SHALL process slice i (bits WIDTH*i+WIDTH-1 : WIDTH*i), i = 0..WORDS-1, LSB slice first, and register that slice's carry-out as the next slice's carry-in.
REQ-019 Add slice: {cout, s} = a_i + b_i + cin, computed at WIDTH+1 bits.
REQ-020 Sub slice: s = a_i - b_i - cin, modulo 2^WIDTH; cout = 1 when a_i < b_i + cin (borrow), compared at WIDTH+1 bits.
REQ-021 At edge k+WORDS SHALL enter DONE and load y, c_out (last slice carry-out) and z_out together; busy=0 and done=1 for exactly the following cycle.
REQ-022 Latency SHALL be WORDS+1 edges from sampled start to done high. Back-to-back operation: start=1 while in DONE SHALL be accepted (DONE -> RUN) with no idle cycle.
REQ-023 DONE + start=0: SHALL return to IDLE at the next edge.
REQ-024 start while busy=1 SHALL be ignored; operand changes during RUN SHALL NOT affect the result.
REQ-025 abort=1 in RUN: SHALL return to IDLE at the next edge, with no done pulse and y/c_out/z_out unchanged. abort and start together while busy=0: start SHALL win.
REQ-026 abort=1 at the same edge the last slice completes (index WORDS-1): abort SHALL win; no update, no done.
REQ-027 y, c_out and z_out SHALL change only at a completion edge (REQ-021) or on reset, and SHALL hold their values otherwise.
REQ-028 WORDS=1 SHALL be legal: done one edge after RUN entry.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, y=0, c_out=0, z_out=0, and clear the slice index and working registers, independent of clk.
REQ-030 Reset during RUN SHALL discard the operation; no done SHALL follow reset release.
REQ-031 The first start SHALL be sampled no earlier than the first rising edge after rst_n rises.

Verification (WIDTH=8, WORDS=4)
REQ-032 add, use_c=0, a=0x0000FFFF, b=0x00000001 -> y=0x00010000, c_out=0, z_out=0; done high exactly 5 edges after start sampled; busy high for 4 cycles.
REQ-033 add, a=0xFFFFFFFF, b=0x00000001 -> y=0x00000000, c_out=1, z_out=1. Then sub, a=0, b=1 -> y=0xFFFFFFFF, c_out=1, z_out=0.
REQ-034 sub, use_c=1, c_in=1, a=0x00000010, b=0x0000000F -> y=0, c_out=0, z_out=1. Same operands with use_c=0 -> y=1, z_out=0.
REQ-035 start pulsed again mid-RUN with different operands -> ignored, first result unaffected. start held high through DONE -> second operation begins with no idle cycle, and done pulses 5 edges apart.
REQ-036 abort asserted at the 2nd RUN edge -> IDLE, no done, y keeps its previous value. rst_n pulsed low mid-RUN -> all outputs 0 immediately, no done after release.
